// File: rtl/seq_divider16.sv
// seq_divider16 -- sequential unsigned restoring divider.
//
// Computes iDividend / iDivisor one quotient bit per clock. A start is only
// accepted while the block is not iterating (IDLE or DONE). Results are held
// in dedicated registers that change only on the edge entering DONE, so they
// always show the last completed operation.
//
// Ports:
//   iClk        clock, all state changes on the rising edge
//   iRst        synchronous active-high reset
//   iStart      start request, ignored while oBusy=1
//   iDividend   dividend, captured on an accepted start
//   iDivisor    divisor, captured on an accepted start
//   oBusy       high while iterating (exactly WIDTH cycles per division)
//   oDone       one-cycle pulse, results valid from this cycle
//   oQuotient   last completed quotient (all ones after divide by zero)
//   oRemainder  last completed remainder (dividend after divide by zero)
//   oDivByZero  last completed operation had a zero divisor
module seq_divider16 #(
  parameter int WIDTH = 16
) (
  input  logic             iClk,
  input  logic             iRst,
  input  logic             iStart,
  input  logic [WIDTH-1:0] iDividend,
  input  logic [WIDTH-1:0] iDivisor,
  output logic             oBusy,
  output logic             oDone,
  output logic [WIDTH-1:0] oQuotient,
  output logic [WIDTH-1:0] oRemainder,
  output logic             oDivByZero
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_next;

  logic [CW-1:0]    iter_count;
  logic [WIDTH:0]   rem_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] div_q;

  logic             accept;
  logic             last_iter;
  logic [WIDTH:0]   trial;
  logic [WIDTH+1:0] sum;
  logic             carry;
  logic [WIDTH:0]   rem_next;
  logic [WIDTH-1:0] quo_next;

  // The partial remainder never exceeds the divisor after a restoring step,
  // so its top bit is architectural headroom that nothing downstream reads.
  logic unused_rem_msb;
  assign unused_rem_msb = rem_q[WIDTH];

  always_ff @(posedge iClk) begin
    if (iRst) state <= IDLE;
    else      state <= state_next;
  end

  // DONE behaves like IDLE for starts so back-to-back divisions lose no
  // cycle; a zero divisor skips iteration and lands in DONE immediately.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    last_iter  = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (iStart) begin
          accept     = 1'b1;
          state_next = (iDivisor == '0) ? DONE : RUN;
        end else if (state == DONE) begin
          state_next = IDLE;
        end
      end
      RUN: begin
        if (iter_count == CW'(WIDTH - 1)) begin
          last_iter  = 1'b1;
          state_next = DONE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Trial subtraction as an add of the complemented divisor with carry-in 1;
  // the extra top bit of the sum is the carry-out, i.e. trial >= divisor.
  always_comb begin
    trial    = {rem_q[WIDTH-1:0], quo_q[WIDTH-1]};
    sum      = {1'b0, trial} + {1'b0, ~{1'b0, div_q}} + {{(WIDTH+1){1'b0}}, 1'b1};
    carry    = sum[WIDTH+1];
    rem_next = carry ? sum[WIDTH:0] : trial;
    quo_next = {quo_q[WIDTH-2:0], carry};
  end

  // Working registers and result registers. Results are written from the
  // next-iteration values on the final edge so they appear with oDone.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      iter_count <= '0;
      rem_q      <= '0;
      quo_q      <= '0;
      div_q      <= '0;
      oQuotient  <= '0;
      oRemainder <= '0;
      oDivByZero <= 1'b0;
    end else if (accept) begin
      iter_count <= '0;
      rem_q      <= '0;
      quo_q      <= iDividend;
      div_q      <= iDivisor;
      if (iDivisor == '0) begin
        oQuotient  <= '1;
        oRemainder <= iDividend;
        oDivByZero <= 1'b1;
      end
    end else if (state == RUN) begin
      iter_count <= iter_count + CW'(1);
      rem_q      <= rem_next;
      quo_q      <= quo_next;
      if (last_iter) begin
        oQuotient  <= quo_next;
        oRemainder <= rem_next[WIDTH-1:0];
        oDivByZero <= 1'b0;
      end
    end
  end

  assign oBusy = (state == RUN);
  assign oDone = (state == DONE);

endmodule
